decap_bank_seq: RTL

- Sequencer for a bank of NSEG switched decap/power-switch segments built from the StdCellLambdaLib cells.
- Turns segments on and off one at a time, with a programmable step interval, to limit inrush current and supply bounce.
- Takes one level request and drives thermometer-coded segment enables plus a power-good flag.
- Sits between the power-management control logic and the segment switch cells.

---
 rtl/decap_bank_seq_pkg.sv | 27 ++
 rtl/decap_step_timer.sv | 33 +++
 rtl/decap_bank_seq.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/decap_bank_seq_pkg.sv
// decap_bank_seq_pkg: shared types and helpers for the decap bank sequencer.
// Optional feature macro used by the sequencer: DECAP_BANK_SEQ_ABORT_EN.
package decap_bank_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_UP  = 2'd1,
    ST_ON  = 2'd2,
    ST_DN  = 2'd3
  } state_t;

  // Width needed to hold a segment count in the range 0..nseg
  function automatic int seg_cnt_w(input int nseg);
    return $clog2(nseg + 1);
  endfunction

  // Effective step interval: a programmed 0 behaves like 1
  function automatic logic [31:0] eff_step(input logic [31:0] x);
    if (x == 32'd0) begin
      return 32'd1;
    end else begin
      return x;
    end
  endfunction

endpackage

// File: rtl/decap_step_timer.sv
// decap_step_timer: down-counter that paces segment transitions.
// expire is high while enabled and the count sits at 1; load wins over counting.
module decap_step_timer
  import decap_bank_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: reload on request, otherwise count down toward zero
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expire = en && (cnt_r == CNT_W'(1));

endmodule

// File: rtl/decap_bank_seq.sv
// decap_bank_seq: ramps a bank of NSEG decap/power-switch segments on and off
// one segment per step interval. Optional macro DECAP_BANK_SEQ_ABORT_EN lets a
// ramp reverse direction when pwr_req changes mid-ramp.
module decap_bank_seq
  import decap_bank_seq_pkg::*;
#(
  parameter int NSEG  = 8,
  parameter int CNT_W = 8
) (
  input  logic                         ck,
  input  logic                         nrst,
  input  logic                         pwr_req,
  input  logic [CNT_W-1:0]             step_cycles,
  output logic [NSEG-1:0]              seg_en,
  output logic                         pwr_good,
  output logic                         busy,
  output logic [seg_cnt_w(NSEG)-1:0]   seg_cnt
);

  localparam int CW = seg_cnt_w(NSEG);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] step_r, step_n;
  logic [NSEG-1:0]  seg_n;
  logic             good_n, busy_n;
  logic [CW-1:0]    cnt_n;
  logic             tmr_load_s, tmr_en_s, tmr_exp_s;
  logic [CNT_W-1:0] tmr_val_s, step_eff_s;
  logic             abort_up_s, abort_dn_s;

  assign step_eff_s = CNT_W'(eff_step(32'(step_cycles)));

`ifdef DECAP_BANK_SEQ_ABORT_EN
  assign abort_up_s = ~pwr_req;
  assign abort_dn_s = pwr_req;
`else
  assign abort_up_s = 1'b0;
  assign abort_dn_s = 1'b0;
`endif

  decap_step_timer #(.CNT_W(CNT_W)) u_timer (
    .ck       (ck),
    .nrst     (nrst),
    .load     (tmr_load_s),
    .en       (tmr_en_s),
    .load_val (tmr_val_s),
    .expire   (tmr_exp_s)
  );

  // Next-state logic: one segment transition per timer expiry
  always_comb begin
    state_n    = state_r;
    step_n     = step_r;
    seg_n      = seg_en;
    good_n     = pwr_good;
    cnt_n      = seg_cnt;
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    tmr_val_s  = step_r;
    case (state_r)
      ST_OFF: begin
        if (pwr_req) begin
          state_n    = ST_UP;
          step_n     = step_eff_s;
          tmr_load_s = 1'b1;
          tmr_val_s  = step_eff_s;
        end else begin
          state_n = ST_OFF;
        end
      end
      ST_UP: begin
        tmr_en_s = 1'b1;
        if (tmr_exp_s) begin
          tmr_load_s = 1'b1;
          if (seg_en[NSEG-1]) begin
            // settle interval after the last segment has elapsed
            if (abort_up_s) begin
              state_n = ST_DN;
            end else begin
              state_n = ST_ON;
              good_n  = 1'b1;
            end
          end else begin
            seg_n = {seg_en[NSEG-2:0], 1'b1};
            cnt_n = seg_cnt + CW'(1);
            if (abort_up_s) begin
              state_n = ST_DN;
            end else begin
              state_n = ST_UP;
            end
          end
        end else if (abort_up_s) begin
          tmr_load_s = 1'b1;
          if (seg_cnt == CW'(0)) begin
            state_n = ST_OFF;
          end else begin
            state_n = ST_DN;
          end
        end else begin
          state_n = ST_UP;
        end
      end
      ST_ON: begin
        if (!pwr_req) begin
          state_n    = ST_DN;
          good_n     = 1'b0;
          step_n     = step_eff_s;
          tmr_load_s = 1'b1;
          tmr_val_s  = step_eff_s;
        end else begin
          state_n = ST_ON;
        end
      end
      ST_DN: begin
        tmr_en_s = 1'b1;
        if (tmr_exp_s) begin
          tmr_load_s = 1'b1;
          seg_n      = {1'b0, seg_en[NSEG-1:1]};
          cnt_n      = seg_cnt - CW'(1);
          if (seg_cnt == CW'(1)) begin
            state_n = ST_OFF;
          end else if (abort_dn_s) begin
            state_n = ST_UP;
          end else begin
            state_n = ST_DN;
          end
        end else if (abort_dn_s) begin
          // a full bank reversing here just runs the up-ramp settle interval
          tmr_load_s = 1'b1;
          state_n    = ST_UP;
        end else begin
          state_n = ST_DN;
        end
      end
      default: begin
        state_n = ST_OFF;
        seg_n   = {NSEG{1'b0}};
        good_n  = 1'b0;
        cnt_n   = {CW{1'b0}};
      end
    endcase
    busy_n = (state_n == ST_UP) || (state_n == ST_DN);
  end

  // State and registered outputs; reset is an immediate hard-off
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_r  <= ST_OFF;
      step_r   <= CNT_W'(1);
      seg_en   <= {NSEG{1'b0}};
      pwr_good <= 1'b0;
      busy     <= 1'b0;
      seg_cnt  <= {CW{1'b0}};
    end else begin
      state_r  <= state_n;
      step_r   <= step_n;
      seg_en   <= seg_n;
      pwr_good <= good_n;
      busy     <= busy_n;
      seg_cnt  <= cnt_n;
    end
  end

endmodule
